// File: rtl/ysyx_23060096_rf_wb_arbiter.sv
// Register-file write-back arbiter (round-robin ALU/LSU) with a pending-write scoreboard.
// Optional commit-cycle bypass is enabled by defining YSYX_23060096_RFARB_BYPASS_EN.
module ysyx_23060096_rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_waddr,
  input  logic [DATA_WIDTH-1:0] alu_wdata,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] ra,
  input  logic [ADDR_WIDTH-1:0] rb,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic                  fwd_a,
  output logic                  fwd_b
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic                  r_last_lsu;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NREG-1:1]       r_busy;

  logic                  w_gnt_alu;
  logic                  w_gnt_lsu;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [NREG-1:0]       w_busy;
  logic                  w_issue_fire;
  logic [NREG-1:1]       w_set;
  logic [NREG-1:1]       w_clr;

  // On a tie the requester that did not win last time is granted.
  assign w_gnt_alu  = alu_valid && (!lsu_valid || r_last_lsu);
  assign w_gnt_lsu  = lsu_valid && (!alu_valid || !r_last_lsu);
  assign w_accept   = w_gnt_alu || w_gnt_lsu;
  assign w_sel_addr = w_gnt_lsu ? lsu_waddr : alu_waddr;
  assign w_sel_data = w_gnt_lsu ? lsu_wdata : alu_wdata;
  assign alu_ready  = w_gnt_alu;
  assign lsu_ready  = w_gnt_lsu;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_lsu <= 1'b1;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_wen <= w_accept && (w_sel_addr != '0);
      if (w_accept) begin
        r_last_lsu <= w_gnt_lsu;
        r_waddr    <= w_sel_addr;
        r_wdata    <= w_sel_data;
      end
    end
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

  assign w_busy       = {r_busy, 1'b0};
  assign issue_ready  = !w_busy[issue_rd];
  assign w_issue_fire = issue_valid && issue_ready && (issue_rd != '0);

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_busy
      assign w_set[gi] = w_issue_fire && (issue_rd == ADDR_WIDTH'(gi));
      assign w_clr[gi] = r_wen && (r_waddr == ADDR_WIDTH'(gi));
    end
  endgenerate

  // Set is applied after clear so a new producer wins over a same-index commit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

`ifdef YSYX_23060096_RFARB_BYPASS_EN
  assign fwd_a = r_wen && (r_waddr == ra) && (ra != '0);
  assign fwd_b = r_wen && (r_waddr == rb) && (rb != '0);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign hazard_a = w_busy[ra] & ~fwd_a;
  assign hazard_b = w_busy[rb] & ~fwd_b;

endmodule

// File: tb/tb_ysyx_23060096_rf_wb_arbiter.sv
// Directed self-checking bench for the write-back arbiter and scoreboard.
// Expectations for the commit-cycle bypass follow YSYX_23060096_RFARB_BYPASS_EN.
module tb_ysyx_23060096_rf_wb_arbiter;

  logic        clk;
  logic        rstn;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        hazard_a;
  logic        hazard_b;
  logic        fwd_a;
  logic        fwd_b;

  int n_checks;
  int n_fail;

`ifdef YSYX_23060096_RFARB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  ysyx_23060096_rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .ra(ra), .rb(rb), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_waddr = 0; alu_wdata = 0;
    lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
    issue_valid = 0; issue_rd = 0; ra = 0; rb = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    idle_inputs();
    tick(); tick();
    #1;
    n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b expected 0", rf_wen); end
    n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d expected 0", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", rf_wdata); end
    rstn = 1;
    tick(); tick();
    for (int i = 0; i < 32; i++) begin
      issue_rd = 5'(i); ra = 5'(i); rb = 5'(31 - i);
      #1;
      n_checks++;
      if (issue_ready !== 1'b1 || hazard_a !== 1'b0 || hazard_b !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_rd%0d: got ready=%b ha=%b hb=%b expected ready=1 ha=0 hb=0", i, issue_ready, hazard_a, hazard_b);
      end
    end
    n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL idle_wen: got %b expected 0", rf_wen); end
    // Reset in the middle of a pending x5 write.
    idle_inputs();
    issue_valid = 1; issue_rd = 5; ra = 5;
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_waddr = 5; alu_wdata = 32'h0000_0055;
    tick();
    alu_valid = 0;
    #1;
    n_checks++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL midwrite_wen_before: got %b expected 1", rf_wen); end
    rstn = 0;
    #1;
    n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL async_reset_wen: got %b expected 0", rf_wen); end
    n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy5: got %b expected 0", hazard_a); end
    n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL async_reset_waddr: got %0d expected 0", rf_waddr); end
    tick();
    rstn = 1;
    tick();
    n_checks++; if (rf_wen !== 1'b0 || hazard_a !== 1'b0) begin n_fail++; $display("FAIL post_reset: got wen=%b ha=%b expected 0 0", rf_wen, hazard_a); end
    $display("test_reset done");
  endtask

  task automatic test_basic_write();
    idle_inputs();
    issue_valid = 1; issue_rd = 5; ra = 5;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL basic_issue_ready: got %b expected 1", issue_ready); end
    n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL basic_hazard_pre: got %b expected 0", hazard_a); end
    tick();
    issue_valid = 0;
    #1;
    n_checks++; if (hazard_a !== 1'b1) begin n_fail++; $display("FAIL basic_hazard_pending: got %b expected 1", hazard_a); end
    tick();
    alu_valid = 1; alu_waddr = 5; alu_wdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin n_fail++; $display("FAIL basic_grant: got alu=%b lsu=%b expected 1 0", alu_ready, lsu_ready); end
    n_checks++; if (hazard_a !== 1'b1) begin n_fail++; $display("FAIL basic_hazard_accept: got %b expected 1", hazard_a); end
    tick();
    alu_valid = 0;
    #1;
    n_checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL basic_commit: got wen=%b addr=%0d data=%h expected 1 5 deadbeef", rf_wen, rf_waddr, rf_wdata);
    end
    n_checks++; if (hazard_a !== ~BYP) begin n_fail++; $display("FAIL basic_hazard_commit: got %b expected %b", hazard_a, ~BYP); end
    n_checks++; if (fwd_a !== BYP) begin n_fail++; $display("FAIL basic_fwd_commit: got %b expected %b", fwd_a, BYP); end
    tick();
    n_checks++;
    if (rf_wen !== 1'b0 || hazard_a !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL basic_after: got wen=%b ha=%b addr=%0d data=%h expected 0 0 5 deadbeef", rf_wen, hazard_a, rf_waddr, rf_wdata);
    end
    $display("test_basic_write done");
  endtask

  task automatic test_x0();
    idle_inputs();
    issue_valid = 1; issue_rd = 0; ra = 0;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL x0_issue_ready: got %b expected 1", issue_ready); end
    tick();
    issue_valid = 0;
    lsu_valid = 1; lsu_waddr = 0; lsu_wdata = 32'h0000_1234;
    #1;
    n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL x0_hazard: got %b expected 0", hazard_a); end
    n_checks++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin n_fail++; $display("FAIL x0_grant: got lsu=%b alu=%b expected 1 0", lsu_ready, alu_ready); end
    tick();
    lsu_valid = 0;
    #1;
    n_checks++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL x0_commit: got wen=%b addr=%0d data=%h expected 0 0 00001234", rf_wen, rf_waddr, rf_wdata);
    end
    n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL x0_hazard_after: got %b expected 0", hazard_a); end
    tick();
    $display("test_x0 done");
  endtask

  task automatic test_round_robin();
    idle_inputs();
    alu_valid = 1; alu_waddr = 1; alu_wdata = 32'h0000_0100;
    lsu_valid = 1; lsu_waddr = 2; lsu_wdata = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      logic exp_alu;
      exp_alu = (i % 2 == 0);
      #1;
      n_checks++;
      if (alu_ready !== exp_alu || lsu_ready !== ~exp_alu) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got alu=%b lsu=%b expected %b %b", i, alu_ready, lsu_ready, exp_alu, ~exp_alu);
      end
      tick();
      if (i == 3) begin alu_valid = 0; lsu_valid = 0; end
      #1;
      n_checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== (exp_alu ? 5'd1 : 5'd2) || rf_wdata !== (exp_alu ? 32'h100 : 32'h200)) begin
        n_fail++;
        $display("FAIL rr_commit%0d: got wen=%b addr=%0d data=%h expected 1 %0d %h", i, rf_wen, rf_waddr, rf_wdata,
                 exp_alu ? 1 : 2, exp_alu ? 32'h100 : 32'h200);
      end
    end
    tick();
    n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b expected 0", rf_wen); end
    $display("test_round_robin done");
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    ra = 7; rb = 7;
    issue_valid = 1; issue_rd = 7;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sb_first_issue: got %b expected 1", issue_ready); end
    tick();
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sb_reissue_blocked: got %b expected 0", issue_ready); end
    n_checks++; if (hazard_a !== 1'b1 || hazard_b !== 1'b1) begin n_fail++; $display("FAIL sb_hazards: got %b %b expected 1 1", hazard_a, hazard_b); end
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_waddr = 7; alu_wdata = 32'h77;
    tick();
    // First commit of x7 now on the write port; a second x7 write is accepted.
    alu_wdata = 32'h78;
    #1;
    n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin n_fail++; $display("FAIL sb_commit1: got wen=%b addr=%0d expected 1 7", rf_wen, rf_waddr); end
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sb_clear_not_visible: got %b expected 0", issue_ready); end
    tick();
    alu_valid = 0;
    issue_valid = 1; issue_rd = 7;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sb_ready_after_clear: got %b expected 1", issue_ready); end
    n_checks++; if (rf_wen !== 1'b1 || rf_wdata !== 32'h78) begin n_fail++; $display("FAIL sb_commit2: got wen=%b data=%h expected 1 00000078", rf_wen, rf_wdata); end
    n_checks++; if (hazard_b !== 1'b0) begin n_fail++; $display("FAIL sb_hazard_clear: got %b expected 0", hazard_b); end
    tick();
    issue_valid = 0;
    #1;
    n_checks++; if (hazard_a !== 1'b1 || issue_ready !== 1'b0) begin n_fail++; $display("FAIL sb_set_wins: got ha=%b ready=%b expected 1 0", hazard_a, issue_ready); end
    alu_valid = 1; alu_waddr = 7; alu_wdata = 32'h79;
    tick();
    alu_valid = 0;
    tick();
    n_checks++; if (hazard_a !== 1'b0) begin n_fail++; $display("FAIL sb_final_clear: got %b expected 0", hazard_a); end
    $display("test_scoreboard done");
  endtask

  task automatic test_bypass();
    idle_inputs();
    ra = 9; rb = 3;
    issue_valid = 1; issue_rd = 9;
    tick();
    issue_valid = 0;
    tick();
    n_checks++; if (hazard_a !== 1'b1 || fwd_a !== 1'b0) begin n_fail++; $display("FAIL byp_pending: got ha=%b fa=%b expected 1 0", hazard_a, fwd_a); end
    lsu_valid = 1; lsu_waddr = 9; lsu_wdata = 32'hA5A5_A5A5;
    tick();
    lsu_valid = 0;
    #1;
    n_checks++; if (rf_wdata !== 32'hA5A5_A5A5 || rf_wen !== 1'b1) begin n_fail++; $display("FAIL byp_data: got wen=%b data=%h expected 1 a5a5a5a5", rf_wen, rf_wdata); end
    n_checks++; if (fwd_a !== BYP) begin n_fail++; $display("FAIL byp_fwd_a: got %b expected %b", fwd_a, BYP); end
    n_checks++; if (hazard_a !== ~BYP) begin n_fail++; $display("FAIL byp_hazard_a: got %b expected %b", hazard_a, ~BYP); end
    n_checks++; if (fwd_b !== 1'b0 || hazard_b !== 1'b0) begin n_fail++; $display("FAIL byp_b: got fb=%b hb=%b expected 0 0", fwd_b, hazard_b); end
    tick();
    n_checks++; if (fwd_a !== 1'b0 || hazard_a !== 1'b0) begin n_fail++; $display("FAIL byp_after: got fa=%b ha=%b expected 0 0", fwd_a, hazard_a); end
    $display("test_bypass done");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic_write();
    test_x0();
    test_round_robin();
    test_scoreboard();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
